// File: rtl/logger_pkg.sv
// Shared constants, FSM state encoding and byte-select helper for the
// sensor-logger transmit scheduler.
package logger_pkg;

  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;
  localparam int DATA_W = 32;
  localparam int NBYTES = DATA_W / 8;
  localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(NBYTES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WRITE,
    S_RD_ADDR,
    S_RD_WAIT,
    S_LOAD,
    S_SEND,
    S_WAIT_DONE,
    S_NEXT,
    S_CLEAR
  } state_e;

  function automatic logic [7:0] byte_sel(input logic [DATA_W-1:0] word,
                                          input logic [BIDX_W-1:0] idx);
    return word[8*idx +: 8];
  endfunction

endpackage

// File: rtl/logger_byte_serializer.sv
// Holds one record and presents it to the UART a byte at a time, LSB first,
// with a one-cycle start pulse per byte.
module logger_byte_serializer
  import logger_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              step_i,
  output logic              last_o,
  output logic              tx_en_o,
  output logic [7:0]        tx_data_o
);

  logic [DATA_W-1:0] word_q;
  logic [BIDX_W-1:0] byte_idx_q;
  logic [BIDX_W-1:0] byte_idx_nxt;
  logic              tx_en_q;
  logic [7:0]        tx_data_q;

  assign byte_idx_nxt = byte_idx_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      word_q     <= '0;
      byte_idx_q <= '0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_en_q <= 1'b0;
      if (load_i) begin
        word_q     <= word_i;
        byte_idx_q <= '0;
        tx_en_q    <= 1'b1;
        tx_data_q  <= byte_sel(word_i, '0);
      end else if (step_i) begin
        byte_idx_q <= byte_idx_nxt;
        tx_en_q    <= 1'b1;
        tx_data_q  <= byte_sel(word_q, byte_idx_nxt);
      end
    end
  end

  assign last_o    = (byte_idx_q == BIDX_LAST);
  assign tx_en_o   = tx_en_q;
  assign tx_data_o = tx_data_q;

endmodule

// File: rtl/logger_tx_scheduler.sv
// Record-RAM and UART sequencing for the sensor logger: stores samples on
// record ticks and dumps the whole buffer on transmit ticks.
//
// state     | meaning
// IDLE      | waiting for a record or transmit tick
// WRITE     | one-cycle RAM write of the held sample
// RD_ADDR   | read address presented to the RAM
// RD_WAIT   | RAM read latency
// LOAD      | read data captured by the serializer
// SEND      | Tx_En pulse for the current byte
// WAIT_DONE | waiting for the UART to finish the byte
// NEXT      | advance to the next record or finish
// CLEAR     | buffer emptied; flush a pending record if any
module logger_tx_scheduler
  import logger_pkg::*;
(
  input  logic              in_Clk,
  input  logic              in_RST,
  input  logic              in_Record_Tick,
  input  logic              in_Transmit_Tick,
  input  logic [DATA_W-1:0] in_Sample,
  output logic              out_Ram_We,
  output logic [ADDR_W-1:0] out_Ram_Addr,
  output logic [DATA_W-1:0] out_Ram_Wdata,
  input  logic [DATA_W-1:0] in_Ram_Rdata,
  output logic              out_Tx_En,
  output logic [7:0]        out_Tx_Data,
  input  logic              in_Tx_Done,
  output logic              out_Busy,
  output logic [CNT_W-1:0]  out_Count,
  output logic              out_Overflow
);

  state_e            state_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;
  logic [CNT_W-1:0]  limit_q;
  logic [CNT_W-1:0]  rd_idx_q;
  logic              pend_v_q;
  logic [DATA_W-1:0] pend_data_q;
  logic              tx_pend_q;

  logic              rec_req;
  logic [DATA_W-1:0] rec_data;
  logic              pend_consume;
  logic              pend_load;
  logic [CNT_W-1:0]  rd_idx_nxt;
  logic              ser_load;
  logic              ser_step;
  logic              ser_last;

  // A latched record is served ahead of a fresh tick; the fresh tick then
  // refills the latch in the same cycle.
  assign rec_req      = in_Record_Tick || pend_v_q;
  assign rec_data     = pend_v_q ? pend_data_q : in_Sample;
  assign pend_consume = pend_v_q && (state_q == S_IDLE || state_q == S_CLEAR);
  assign pend_load    = in_Record_Tick && (state_q != S_IDLE || pend_v_q);
  assign rd_idx_nxt   = rd_idx_q + 1'b1;
  assign ser_load     = (state_q == S_LOAD);
  assign ser_step     = (state_q == S_WAIT_DONE) && in_Tx_Done && !ser_last;

  always_ff @(posedge in_Clk or negedge in_RST) begin
    if (!in_RST) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      limit_q     <= '0;
      rd_idx_q    <= '0;
      pend_v_q    <= 1'b0;
      pend_data_q <= '0;
      tx_pend_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rec_req && count_q < CNT_FULL) begin
            we_q      <= 1'b1;
            addr_q    <= count_q[ADDR_W-1:0];
            wdata_q   <= rec_data;
            tx_pend_q <= in_Transmit_Tick;
            state_q   <= S_WRITE;
          end else begin
            if (rec_req) ovf_q <= 1'b1;
            if (in_Transmit_Tick && count_q != '0) begin
              limit_q  <= count_q;
              rd_idx_q <= '0;
              addr_q   <= '0;
              state_q  <= S_RD_ADDR;
            end
          end
        end
        S_WRITE: begin
          count_q <= count_q + 1'b1;
          if (tx_pend_q) begin
            tx_pend_q <= 1'b0;
            limit_q   <= count_q + 1'b1;
            rd_idx_q  <= '0;
            addr_q    <= '0;
            state_q   <= S_RD_ADDR;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RD_ADDR:   state_q <= S_RD_WAIT;
        S_RD_WAIT:   state_q <= S_LOAD;
        S_LOAD:      state_q <= S_SEND;
        S_SEND:      state_q <= S_WAIT_DONE;
        S_WAIT_DONE: if (in_Tx_Done) state_q <= ser_last ? S_NEXT : S_SEND;
        S_NEXT: begin
          rd_idx_q <= rd_idx_nxt;
          if (rd_idx_nxt < limit_q) begin
            addr_q  <= rd_idx_nxt[ADDR_W-1:0];
            state_q <= S_RD_ADDR;
          end else begin
            state_q <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          count_q <= '0;
          ovf_q   <= 1'b0;
          if (pend_v_q) begin
            we_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= pend_data_q;
            state_q <= S_WRITE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (pend_load) begin
        if (!pend_v_q || pend_consume) begin
          pend_v_q    <= 1'b1;
          pend_data_q <= in_Sample;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (pend_consume) begin
        pend_v_q <= 1'b0;
      end
    end
  end

  logger_byte_serializer u_ser (
    .clk_i     (in_Clk),
    .rst_n_i   (in_RST),
    .load_i    (ser_load),
    .word_i    (in_Ram_Rdata),
    .step_i    (ser_step),
    .last_o    (ser_last),
    .tx_en_o   (out_Tx_En),
    .tx_data_o (out_Tx_Data)
  );

  assign out_Ram_We    = we_q;
  assign out_Ram_Addr  = addr_q;
  assign out_Ram_Wdata = wdata_q;
  assign out_Busy      = (state_q != S_IDLE);
  assign out_Count     = count_q;
  assign out_Overflow  = ovf_q;

endmodule
